// File: rtl/ase_pcie_ss_dma_rd_tag_mgr_pkg.sv
// Shared PCIe SS emulation types: configuration defaults, DMA read tag state and tag manager FSM states.
package ase_pcie_ss_dma_rd_tag_mgr_pkg;

   // Emulated PCIe SS configuration knobs relevant to DMA reads
   typedef struct packed {
      int unsigned max_outstanding_dma_rd_reqs;
      int unsigned max_rd_req_bytes;
   } t_ase_pcie_ss_param_cfg;

   localparam t_ase_pcie_ss_param_cfg ASE_PCIE_SS_PARAM_CFG_DEFAULT = '{
      max_outstanding_dma_rd_reqs: 32'd256,
      max_rd_req_bytes:            32'd4096
   };

   localparam int unsigned DMA_RD_NUM_TAGS_DEFAULT      = ASE_PCIE_SS_PARAM_CFG_DEFAULT.max_outstanding_dma_rd_reqs;
   localparam int unsigned DMA_RD_MAX_REQ_BYTES_DEFAULT = ASE_PCIE_SS_PARAM_CFG_DEFAULT.max_rd_req_bytes;

   // Remaining-byte field holds any legal request length of the default configuration
   localparam int unsigned DMA_RD_LEN_W = $clog2(DMA_RD_MAX_REQ_BYTES_DEFAULT) + 1;

   typedef struct packed {
      logic                    busy;
      logic [DMA_RD_LEN_W-1:0] remaining;
   } t_dma_rd_tag_state;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } t_tag_mgr_state;

endpackage

// File: rtl/ase_pcie_ss_tag_fifo.sv
// Free-tag FIFO: registered head, same-cycle push/pop at any occupancy.
module ase_pcie_ss_tag_fifo #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             nonempty_nxt_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             bypass;

   // Next pointers/count; a push becomes the head directly when nothing older survives the edge
   always_comb begin
      rd_ptr_d       = rd_ptr_q + AW'(pop_i);
      wr_ptr_d       = wr_ptr_q + AW'(push_i);
      cnt_d          = cnt_q + CW'(push_i) - CW'(pop_i);
      bypass         = push_i && ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop_i));
      head_d         = bypass ? push_data_i : mem_q[rd_ptr_d];
      nonempty_nxt_o = (cnt_d != '0);
   end

   // Pointer, count and head registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
      end
   end

   // Storage write port
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o = head_q;

   a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
      !(push_i && (cnt_q == CW'(DEPTH))));
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
      !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/ase_pcie_ss_dma_rd_tag_mgr.sv
// DMA read tag manager: allocates tags from a free list and frees them once all requested bytes complete.
module ase_pcie_ss_dma_rd_tag_mgr
   import ase_pcie_ss_dma_rd_tag_mgr_pkg::*;
#(
   parameter  int unsigned NUM_TAGS         = DMA_RD_NUM_TAGS_DEFAULT,
   parameter  int unsigned MAX_RD_REQ_BYTES = DMA_RD_MAX_REQ_BYTES_DEFAULT,
   localparam int unsigned TAG_W            = $clog2(NUM_TAGS),
   localparam int unsigned LEN_W            = $clog2(MAX_RD_REQ_BYTES) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             alloc_valid_i,
   input  logic [LEN_W-1:0] alloc_len_i,
   output logic             alloc_ready_o,
   output logic [TAG_W-1:0] alloc_tag_o,
   input  logic             cpl_valid_i,
   input  logic [TAG_W-1:0] cpl_tag_i,
   input  logic [LEN_W-1:0] cpl_len_i,
   output logic             cpl_done_o,
   output logic [TAG_W-1:0] cpl_done_tag_o,
   output logic [TAG_W:0]   num_outstanding_o,
   output logic             err_cpl_o
);

   localparam int unsigned CNT_W = TAG_W + 1;

   t_tag_mgr_state          state_q;
   logic [TAG_W-1:0]        init_cnt_q;
   logic                    alloc_ready_q;
   logic                    cpl_done_q;
   logic [TAG_W-1:0]        cpl_done_tag_q;
   logic [CNT_W-1:0]        num_out_q, num_out_d;
   logic                    err_cpl_q;
   t_dma_rd_tag_state       tag_st_q [NUM_TAGS];

   t_dma_rd_tag_state       cur_st;
   logic [DMA_RD_LEN_W-1:0] cpl_len_ext;
   logic                    pop;
   logic                    cpl_ok;
   logic                    cpl_bad;
   logic                    cpl_final;
   logic                    fifo_push;
   logic [TAG_W-1:0]        fifo_data;
   logic [TAG_W-1:0]        fifo_head;
   logic                    fifo_nonempty_nxt;

   // Handshake and completion classification; freed tags enter the FIFO one cycle after the final beat
   always_comb begin
      cur_st      = tag_st_q[cpl_tag_i];
      cpl_len_ext = DMA_RD_LEN_W'(cpl_len_i);
      pop         = alloc_valid_i && alloc_ready_q;
      cpl_ok      = (state_q == ST_RUN) && cpl_valid_i && cur_st.busy &&
                    (cpl_len_i != '0) && (cpl_len_ext <= cur_st.remaining);
      cpl_bad     = cpl_valid_i && !cpl_ok;
      cpl_final   = cpl_ok && (cpl_len_ext == cur_st.remaining);
      fifo_push   = (state_q == ST_INIT) || cpl_done_q;
      fifo_data   = (state_q == ST_INIT) ? init_cnt_q : cpl_done_tag_q;
      num_out_d   = num_out_q + CNT_W'(pop) - CNT_W'(cpl_final);
   end

   ase_pcie_ss_tag_fifo #(
      .DEPTH (NUM_TAGS),
      .WIDTH (TAG_W)
   ) u_free_fifo (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .push_i         (fifo_push),
      .push_data_i    (fifo_data),
      .pop_i          (pop),
      .head_o         (fifo_head),
      .nonempty_nxt_o (fifo_nonempty_nxt)
   );

   // Per-tag state: completion read-modify-write port and allocation write port
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(NUM_TAGS); i++) begin
            tag_st_q[i] <= '0;
         end
      end else begin
         if (cpl_ok) begin
            tag_st_q[cpl_tag_i].remaining <= cur_st.remaining - cpl_len_ext;
            tag_st_q[cpl_tag_i].busy      <= !cpl_final;
         end
         if (pop) begin
            tag_st_q[fifo_head].busy      <= 1'b1;
            tag_st_q[fifo_head].remaining <= DMA_RD_LEN_W'(alloc_len_i);
         end
      end
   end

   // Init/run FSM with registered status outputs
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= ST_INIT;
         init_cnt_q     <= '0;
         alloc_ready_q  <= 1'b0;
         cpl_done_q     <= 1'b0;
         cpl_done_tag_q <= '0;
         num_out_q      <= '0;
         err_cpl_q      <= 1'b0;
      end else begin
         cpl_done_q <= cpl_final;
         if (cpl_final) begin
            cpl_done_tag_q <= cpl_tag_i;
         end
         num_out_q <= num_out_d;
         if (cpl_bad) begin
            err_cpl_q <= 1'b1;
         end
         case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + TAG_W'(1);
               if (init_cnt_q == TAG_W'(NUM_TAGS - 1)) begin
                  state_q       <= ST_RUN;
                  alloc_ready_q <= 1'b1;
               end
            end
            ST_RUN: begin
               alloc_ready_q <= fifo_nonempty_nxt;
            end
            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

   assign alloc_ready_o     = alloc_ready_q;
   assign alloc_tag_o       = fifo_head;
   assign cpl_done_o        = cpl_done_q;
   assign cpl_done_tag_o    = cpl_done_tag_q;
   assign num_outstanding_o = num_out_q;
   assign err_cpl_o         = err_cpl_q;

   a_alloc_len_legal: assert property (@(posedge clk_i) disable iff (reset_i)
      pop |-> ((alloc_len_i != '0) && (alloc_len_i <= LEN_W'(MAX_RD_REQ_BYTES))));
   a_num_out_range: assert property (@(posedge clk_i) disable iff (reset_i)
      num_out_q <= CNT_W'(NUM_TAGS));

endmodule

// File: tb/tb_ase_pcie_ss_dma_rd_tag_mgr.sv
// Bench for the DMA read tag manager: queue/array reference model plus directed traffic.
module tb_ase_pcie_ss_dma_rd_tag_mgr;

   localparam int NT = 256;
   localparam int TW = 8;
   localparam int LW = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          alloc_valid;
   logic [LW-1:0] alloc_len;
   logic          alloc_ready;
   logic [TW-1:0] alloc_tag;
   logic          cpl_valid;
   logic [TW-1:0] cpl_tag;
   logic [LW-1:0] cpl_len;
   logic          cpl_done;
   logic [TW-1:0] cpl_done_tag;
   logic [TW:0]   num_outstanding;
   logic          err_cpl;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ase_pcie_ss_dma_rd_tag_mgr #(
      .NUM_TAGS         (NT),
      .MAX_RD_REQ_BYTES (4096)
   ) dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .alloc_valid_i     (alloc_valid),
      .alloc_len_i       (alloc_len),
      .alloc_ready_o     (alloc_ready),
      .alloc_tag_o       (alloc_tag),
      .cpl_valid_i       (cpl_valid),
      .cpl_tag_i         (cpl_tag),
      .cpl_len_i         (cpl_len),
      .cpl_done_o        (cpl_done),
      .cpl_done_tag_o    (cpl_done_tag),
      .num_outstanding_o (num_outstanding),
      .err_cpl_o         (err_cpl)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: free tags as a queue, per-tag busy flag and byte count
   bit m_busy [NT];
   int m_rem  [NT];
   int m_free [$];
   int m_init;
   bit m_run;
   bit m_ready;
   bit m_done;
   int m_done_tag;
   int m_num;
   bit m_err;
   bit m_pend_v;
   int m_pend;

   initial begin
      forever begin
         bit hs;
         bit ok;
         bit fin;
         int t;
         @(posedge clk);
         if (reset === 1'b1) begin
            for (int i = 0; i < NT; i++) begin
               m_busy[i] = 1'b0;
               m_rem[i]  = 0;
            end
            m_free.delete();
            m_init = 0; m_run = 1'b0; m_ready = 1'b0; m_done = 1'b0;
            m_done_tag = 0; m_num = 0; m_err = 1'b0; m_pend_v = 1'b0; m_pend = 0;
         end else begin
            hs  = alloc_valid && m_ready;
            ok  = m_run && cpl_valid && m_busy[cpl_tag] && (int'(cpl_len) > 0) &&
                  (int'(cpl_len) <= m_rem[cpl_tag]);
            fin = ok && (int'(cpl_len) == m_rem[cpl_tag]);
            if (cpl_valid && !ok) m_err = 1'b1;
            if (ok) begin
               m_rem[cpl_tag] = m_rem[cpl_tag] - int'(cpl_len);
               if (fin) m_busy[cpl_tag] = 1'b0;
            end
            if (hs) begin
               t = m_free.pop_front();
               m_busy[t] = 1'b1;
               m_rem[t]  = int'(alloc_len);
            end
            if (m_pend_v) m_free.push_back(m_pend);
            m_pend_v = fin;
            m_pend   = int'(cpl_tag);
            m_done   = fin;
            if (fin) m_done_tag = int'(cpl_tag);
            if (!m_run) begin
               m_init++;
               if (m_init == NT) begin
                  m_run = 1'b1;
                  for (int i = 0; i < NT; i++) m_free.push_back(i);
               end
            end
            m_num = 0;
            for (int i = 0; i < NT; i++) m_num += int'(m_busy[i]);
            m_ready = m_run && (m_free.size() > 0);
         end
      end
   end

   // Compare every output against the model away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("alloc_ready", 32'(alloc_ready), 32'(m_ready));
            if (m_ready) check("alloc_tag", 32'(alloc_tag), 32'(m_free[0]));
            check("cpl_done", 32'(cpl_done), 32'(m_done));
            check("cpl_done_tag", 32'(cpl_done_tag), 32'(m_done_tag));
            check("num_outstanding", 32'(num_outstanding), 32'(m_num));
            check("err_cpl", 32'(err_cpl), 32'(m_err));
         end
      end
   end

   // One cycle of stimulus, applied at a falling edge
   task automatic drive(input bit av, input int al, input bit cv, input int ct, input int cl);
      alloc_valid = av;
      alloc_len   = LW'(al);
      cpl_valid   = cv;
      cpl_tag     = TW'(ct);
      cpl_len     = LW'(cl);
      @(negedge clk);
      alloc_valid = 1'b0;
      cpl_valid   = 1'b0;
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (alloc_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n), 32'(NT));
   endtask

   initial begin
      int n;
      int t;
      reset = 1'b1;
      alloc_valid = 1'b0; alloc_len = '0;
      cpl_valid = 1'b0; cpl_tag = '0; cpl_len = '0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_num", 32'(num_outstanding), 32'(0));
      reset = 1'b0;

      // Free-list fill after reset
      wait_init("t1_init_cycles");
      check("t1_tag", 32'(alloc_tag), 32'(0));
      check("t1_num", 32'(num_outstanding), 32'(0));

      // Back-to-back allocations
      for (int i = 0; i < 4; i++) begin
         check("t2_tag", 32'(alloc_tag), 32'(i));
         drive(1'b1, 512, 1'b0, 0, 0);
      end
      check("t2_num", 32'(num_outstanding), 32'(4));

      // Tag 1 completed in eight beats
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 0, 1'b1, 1, 64);
         if (i < 7) check("t3_early_done", 32'(cpl_done), 32'(0));
      end
      check("t3_done", 32'(cpl_done), 32'(1));
      check("t3_done_tag", 32'(cpl_done_tag), 32'(1));
      check("t3_num", 32'(num_outstanding), 32'(3));

      // Exhaust the pool, tag 5 carries a full 4 KB request
      n = 0;
      while (alloc_ready === 1'b1 && n < 300) begin
         t = int'(alloc_tag);
         drive(1'b1, (t == 5) ? 4096 : 512, 1'b0, 0, 0);
         n++;
      end
      check("t4_allocs", 32'(n), 32'(253));
      check("t4_empty", 32'(alloc_ready), 32'(0));
      check("t4_num", 32'(num_outstanding), 32'(256));
      drive(1'b0, 0, 1'b1, 5, 4096);
      check("t4_ready_c1", 32'(alloc_ready), 32'(0));
      drive(1'b0, 0, 1'b0, 0, 0);
      check("t4_ready_c2", 32'(alloc_ready), 32'(1));
      check("t4_tag", 32'(alloc_tag), 32'(5));
      drive(1'b1, 512, 1'b0, 0, 0);

      // Overrun on a busy tag leaves its byte count intact
      drive(1'b0, 0, 1'b1, 8, 600);
      check("t5_err_overrun", 32'(err_cpl), 32'(1));
      check("t5_num_keep", 32'(num_outstanding), 32'(256));
      drive(1'b0, 0, 1'b1, 8, 512);
      check("t5_done", 32'(cpl_done), 32'(1));
      check("t5_done_tag", 32'(cpl_done_tag), 32'(8));
      drive(1'b0, 0, 1'b0, 0, 0);
      check("t5_tag8", 32'(alloc_tag), 32'(8));

      // Allocation and final completion in one cycle, then push/pop with one entry
      check("t6_num_before", 32'(num_outstanding), 32'(255));
      drive(1'b1, 512, 1'b1, 2, 512);
      check("t6_num_same", 32'(num_outstanding), 32'(255));
      check("t6_empty", 32'(alloc_ready), 32'(0));
      drive(1'b0, 0, 1'b1, 0, 512);
      check("t6_tag2", 32'(alloc_tag), 32'(2));
      drive(1'b1, 512, 1'b0, 0, 0);
      check("t6_ready_1entry", 32'(alloc_ready), 32'(1));
      check("t6_tag0", 32'(alloc_tag), 32'(0));

      // Reset in the middle of traffic
      reset = 1'b1;
      drive(1'b1, 512, 1'b1, 3, 64);
      check("t6r_ready", 32'(alloc_ready), 32'(0));
      check("t6r_tag", 32'(alloc_tag), 32'(0));
      check("t6r_done", 32'(cpl_done), 32'(0));
      check("t6r_num", 32'(num_outstanding), 32'(0));
      check("t6r_err", 32'(err_cpl), 32'(0));
      drive(1'b0, 0, 1'b0, 0, 0);
      reset = 1'b0;
      wait_init("t6r_init_cycles");

      // Completion to a free tag is sticky
      drive(1'b0, 0, 1'b1, 7, 64);
      check("t5b_err", 32'(err_cpl), 32'(1));
      repeat (3) drive(1'b0, 0, 1'b0, 0, 0);
      check("t5b_err_sticky", 32'(err_cpl), 32'(1));
      check("t5b_num", 32'(num_outstanding), 32'(0));

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
